// File: rtl/sysrst_ctl_if.sv
// sysrst_ctl_if: signal bundle between the reset-request controller and
// its surroundings (board button, PLL, watchdog/software requesters and the
// system manager's rst_in).
//   btn_n         raw reset button, active-low, asynchronous
//   pll_lock      PLL LOCK, asynchronous to clk
//   wdt_en        watchdog enable
//   wdt_kick      one-cycle watchdog restart pulse
//   sw_rst_req    one-cycle software reset request
//   pll_rst_req   active-high reset request to the system manager rst_in
//   running       high only while the controller is in RUN
//   rst_cause     cause of the last request (0 POR,1 BTN,2 LOCK,3 WDT,4 SW)
//   lock_timeouts saturating count of lock timeouts
// slave = the controller, master = whatever drives its inputs.
interface sysrst_ctl_if;
  logic       btn_n;
  logic       pll_lock;
  logic       wdt_en;
  logic       wdt_kick;
  logic       sw_rst_req;
  logic       pll_rst_req;
  logic       running;
  logic [2:0] rst_cause;
  logic [3:0] lock_timeouts;

  modport slave (
    input  btn_n, pll_lock, wdt_en, wdt_kick, sw_rst_req,
    output pll_rst_req, running, rst_cause, lock_timeouts
  );

  modport master (
    output btn_n, pll_lock, wdt_en, wdt_kick, sw_rst_req,
    input  pll_rst_req, running, rst_cause, lock_timeouts
  );
endinterface

// File: rtl/sysrst_ctl.sv
// sysrst_ctl: reset-request controller feeding the system manager rst_in.
// Collects button / lock-loss / watchdog / software reset sources, holds
// pll_rst_req high for PULSE_LEN cycles, then waits for PLL lock with a
// timeout that re-issues the pulse. Clocked from a free-running, non-PLL
// clock so it keeps working while the PLL is held in reset.
// Ports:
//   clk   free-running clock
//   rst_n asynchronous active-low reset
//   bus   sysrst_ctl_if.slave (see interface file for signal list)
// The pulse counter and the lock-wait counter share one LOCK_TO_BITS-wide
// register, so LOCK_TO_BITS must be wide enough to hold PULSE_LEN-1.
module sysrst_ctl #(
  parameter int unsigned PULSE_LEN     = 16,
  parameter int unsigned LOCK_TO_BITS  = 20,
  parameter int unsigned DEBOUNCE_BITS = 16,
  parameter int unsigned WDT_BITS      = 24
) (
  input  logic        clk,
  input  logic        rst_n,
  sysrst_ctl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_ASSERT    = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_RUN       = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    CAUSE_POR  = 3'd0,
    CAUSE_BTN  = 3'd1,
    CAUSE_LOCK = 3'd2,
    CAUSE_WDT  = 3'd3,
    CAUSE_SW   = 3'd4
  } cause_e;

  localparam logic [LOCK_TO_BITS-1:0] PULSE_LAST = LOCK_TO_BITS'(PULSE_LEN - 1);

  // synchronizers
  logic btn_meta_q, btn_meta_d, btn_sync_q, btn_sync_d;
  logic lock_meta_q, lock_meta_d, lock_sync_q, lock_sync_d;

  // debouncer
  logic [DEBOUNCE_BITS-1:0] deb_cnt_q, deb_cnt_d;
  logic                     btn_deb_q, btn_deb_d;
  logic                     btn_armed_q, btn_armed_d;

  // FSM and counters
  state_e                   state_q, state_d;
  logic [LOCK_TO_BITS-1:0]  cnt_q, cnt_d, cnt_inc;
  logic [WDT_BITS-1:0]      wdt_q, wdt_d;
  cause_e                   cause_q, cause_d;
  logic [3:0]               timeouts_q, timeouts_d;
  logic                     pll_rst_req_q, pll_rst_req_d;
  logic                     running_q, running_d;

  logic trig_btn, trig_lock, trig_wdt, trig_sw, trig_any, btn_take;

  always_comb begin
    btn_meta_d  = bus.btn_n;
    btn_sync_d  = btn_meta_q;
    lock_meta_d = bus.pll_lock;
    lock_sync_d = lock_meta_q;

    // Debounce: any sample equal to the current level restarts the count;
    // the level only flips after 2^DEBOUNCE_BITS consecutive differing samples.
    deb_cnt_d = deb_cnt_q;
    btn_deb_d = btn_deb_q;
    if (btn_sync_q == btn_deb_q) begin
      deb_cnt_d = '0;
    end else if (deb_cnt_q == '1) begin
      btn_deb_d = ~btn_deb_q;
      deb_cnt_d = '0;
    end else begin
      deb_cnt_d = deb_cnt_q + 1'b1;
    end

    trig_btn  = ~btn_deb_q & btn_armed_q;
    trig_lock = ~lock_sync_q;
    trig_wdt  = (wdt_q == '1) & ~bus.wdt_kick;
    trig_sw   = bus.sw_rst_req;
    trig_any  = trig_btn | trig_lock | trig_wdt | trig_sw;

    state_d    = state_q;
    cnt_d      = cnt_q;
    cnt_inc    = cnt_q + 1'b1;
    wdt_d      = '0;
    cause_d    = cause_q;
    timeouts_d = timeouts_q;
    btn_take   = 1'b0;

    case (state_q)
      ST_ASSERT: begin
        if (cnt_q == PULSE_LAST) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      ST_WAIT_LOCK: begin
        if (lock_sync_q) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else if (cnt_inc == '1) begin
          // timeout when the count reaches all-ones, i.e. 2^LOCK_TO_BITS-1 cycles
          state_d = ST_ASSERT;
          cnt_d   = '0;
          if (timeouts_q != 4'hF) begin
            timeouts_d = timeouts_q + 4'd1;
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end

      ST_RUN: begin
        if (bus.wdt_kick || !bus.wdt_en) begin
          wdt_d = '0;
        end else if (wdt_q != '1) begin
          wdt_d = wdt_q + 1'b1;
        end else begin
          wdt_d = wdt_q;
        end

        if (trig_any) begin
          state_d = ST_ASSERT;
          cnt_d   = '0;
          wdt_d   = '0;
          if (trig_btn) begin
            cause_d  = CAUSE_BTN;
            btn_take = 1'b1;
          end else if (trig_lock) begin
            cause_d = CAUSE_LOCK;
          end else if (trig_wdt) begin
            cause_d = CAUSE_WDT;
          end else begin
            cause_d = CAUSE_SW;
          end
        end
      end

      default: begin
        state_d = ST_ASSERT;
        cnt_d   = '0;
      end
    endcase

    // Re-arming needs the debounced button back at released, so a held
    // button yields exactly one request.
    btn_armed_d = btn_armed_q;
    if (btn_deb_q) begin
      btn_armed_d = 1'b1;
    end else if (btn_take) begin
      btn_armed_d = 1'b0;
    end

    pll_rst_req_d = (state_d == ST_ASSERT);
    running_d     = (state_d == ST_RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_meta_q    <= 1'b1;
      btn_sync_q    <= 1'b1;
      lock_meta_q   <= 1'b0;
      lock_sync_q   <= 1'b0;
      deb_cnt_q     <= '0;
      btn_deb_q     <= 1'b1;
      btn_armed_q   <= 1'b1;
      state_q       <= ST_ASSERT;
      cnt_q         <= '0;
      wdt_q         <= '0;
      cause_q       <= CAUSE_POR;
      timeouts_q    <= '0;
      pll_rst_req_q <= 1'b1;
      running_q     <= 1'b0;
    end else begin
      btn_meta_q    <= btn_meta_d;
      btn_sync_q    <= btn_sync_d;
      lock_meta_q   <= lock_meta_d;
      lock_sync_q   <= lock_sync_d;
      deb_cnt_q     <= deb_cnt_d;
      btn_deb_q     <= btn_deb_d;
      btn_armed_q   <= btn_armed_d;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      wdt_q         <= wdt_d;
      cause_q       <= cause_d;
      timeouts_q    <= timeouts_d;
      pll_rst_req_q <= pll_rst_req_d;
      running_q     <= running_d;
    end
  end

  assign bus.pll_rst_req   = pll_rst_req_q;
  assign bus.running       = running_q;
  assign bus.rst_cause     = cause_q;
  assign bus.lock_timeouts = timeouts_q;

endmodule

// File: tb/tb_sysrst_ctl.sv
// Directed bench for sysrst_ctl with PULSE_LEN=8, LOCK_TO_BITS=6,
// DEBOUNCE_BITS=3, WDT_BITS=6. The PLL model drops lock as soon as the
// request is high and re-locks once the request has been low for 10 cycles,
// unless lock_force holds it low.
module tb_sysrst_ctl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic lock_force = 1'b0;
  logic [9:0] dly = '1;
  logic prev_req = 1'b1;
  int total = 0;
  int bad = 0;
  int rises = 0;
  int n;

  always #5 clk = ~clk;

  sysrst_ctl_if bus ();

  sysrst_ctl #(
    .PULSE_LEN    (8),
    .LOCK_TO_BITS (6),
    .DEBOUNCE_BITS(3),
    .WDT_BITS     (6)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always @(posedge clk) dly <= {dly[8:0], bus.pll_rst_req};
  assign bus.pll_lock = lock_force ? 1'b0 : ~(bus.pll_rst_req | (|dly));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (bus.pll_rst_req === 1'b1 && prev_req === 1'b0) rises++;
    prev_req = bus.pll_rst_req;
  endtask

  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) tick();
  endtask

  task automatic count_req(input logic lvl, input int limit, output int cnt);
    cnt = 0;
    while (bus.pll_rst_req === lvl && cnt < limit) begin
      tick();
      cnt++;
    end
  endtask

  task automatic wait_running(input int limit, output int cnt);
    cnt = 0;
    while (bus.running !== 1'b1 && cnt < limit) begin
      tick();
      cnt++;
    end
  endtask

  task automatic kick();
    bus.wdt_kick = 1'b1;
    tick();
    bus.wdt_kick = 1'b0;
  endtask

  initial begin
    bus.btn_n      = 1'b1;
    bus.wdt_en     = 1'b0;
    bus.wdt_kick   = 1'b0;
    bus.sw_rst_req = 1'b0;

    // reset state
    run(12);
    check("rst_req", 32'(bus.pll_rst_req), 1);
    check("rst_running", 32'(bus.running), 0);
    check("rst_cause", 32'(bus.rst_cause), 0);
    check("rst_timeouts", 32'(bus.lock_timeouts), 0);

    // POR
    @(negedge clk);
    rst_n = 1'b1;
    count_req(1'b1, 100, n);
    check("por_pulse_len", 32'(n), 8);
    wait_running(100, n);
    check("por_lock_delay", 32'(n), 13);
    check("por_cause", 32'(bus.rst_cause), 0);
    check("por_timeouts", 32'(bus.lock_timeouts), 0);

    // button glitches: 2-cycle lows never reach the 8-cycle debounce
    rises = 0;
    for (int g = 0; g < 2; g++) begin
      bus.btn_n = 1'b0;
      run(2);
      bus.btn_n = 1'b1;
      run(6);
    end
    run(10);
    check("glitch_rises", 32'(rises), 0);
    check("glitch_running", 32'(bus.running), 1);

    // held button: one request, then stays in RUN after re-lock
    rises = 0;
    bus.btn_n = 1'b0;
    run(100);
    check("btn_rises", 32'(rises), 1);
    check("btn_cause", 32'(bus.rst_cause), 1);
    check("btn_running_held", 32'(bus.running), 1);
    rises = 0;
    bus.btn_n = 1'b1;
    run(20);
    check("btn_release_rises", 32'(rises), 0);
    check("btn_release_running", 32'(bus.running), 1);
    bus.btn_n = 1'b0;
    run(30);
    check("btn_repress_rises", 32'(rises), 1);
    check("btn_repress_cause", 32'(bus.rst_cause), 1);
    bus.btn_n = 1'b1;
    wait_running(200, n);

    // watchdog expiry: 63 counts to all-ones, trigger, request next cycle
    bus.wdt_en = 1'b1;
    count_req(1'b0, 200, n);
    check("wdt_latency", 32'(n), 64);
    check("wdt_cause", 32'(bus.rst_cause), 3);
    wait_running(200, n);

    // kicks every 50 cycles
    rises = 0;
    for (int k = 0; k < 4; k++) begin
      kick();
      run(49);
    end
    check("wdt_kick_rises", 32'(rises), 0);
    check("wdt_kick_running", 32'(bus.running), 1);

    // kick landing exactly when the watchdog sits at all-ones
    kick();
    run(63);
    kick();
    run(5);
    check("wdt_coinc_rises", 32'(rises), 0);
    check("wdt_coinc_running", 32'(bus.running), 1);
    bus.wdt_en = 1'b0;

    // priority: sw pulse lined up with the synchronised lock drop
    lock_force = 1'b1;
    run(2);
    check("prio_pre_req", 32'(bus.pll_rst_req), 0);
    bus.sw_rst_req = 1'b1;
    tick();
    bus.sw_rst_req = 1'b0;
    check("prio_req", 32'(bus.pll_rst_req), 1);
    check("prio_cause", 32'(bus.rst_cause), 2);
    lock_force = 1'b0;
    wait_running(200, n);

    // software request alone, one-cycle latency
    check("sw_pre_req", 32'(bus.pll_rst_req), 0);
    bus.sw_rst_req = 1'b1;
    tick();
    bus.sw_rst_req = 1'b0;
    check("sw_req", 32'(bus.pll_rst_req), 1);
    check("sw_cause", 32'(bus.rst_cause), 4);

    // lock timeouts with lock stuck low
    lock_force = 1'b1;
    count_req(1'b1, 20, n);
    count_req(1'b0, 200, n);
    check("to_wait_len", 32'(n), 63);
    count_req(1'b1, 20, n);
    check("to_pulse_len", 32'(n), 8);
    check("to_first", 32'(bus.lock_timeouts), 1);
    run(71 * 15);
    check("to_saturate", 32'(bus.lock_timeouts), 15);
    check("to_cause_kept", 32'(bus.rst_cause), 4);

    // asynchronous reset in WAIT_LOCK
    count_req(1'b1, 20, n);
    run(5);
    check("async_pre_req", 32'(bus.pll_rst_req), 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_req", 32'(bus.pll_rst_req), 1);
    check("async_timeouts", 32'(bus.lock_timeouts), 0);
    check("async_running", 32'(bus.running), 0);
    check("async_cause", 32'(bus.rst_cause), 0);
    lock_force = 1'b0;
    run(12);
    @(negedge clk);
    rst_n = 1'b1;
    count_req(1'b1, 100, n);
    check("async_pulse_len", 32'(n), 8);
    wait_running(100, n);
    check("async_relock", 32'(n), 13);
    check("async_final_cause", 32'(bus.rst_cause), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
